// File: rtl/sfq_clocked_gate_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfq_clocked_gate_n_pkg
// Description : Shared types, constants and the gate-function evaluator for
//               the clocked SFQ gate family.
// Contents    : sfq_gate_mode_e  - gate function selector (AND/OR/XOR/MAJ)
//               SFQ_MODE_W       - width of the mode selector
//               SFQ_MAX_INPUTS   - widest input vector sfq_gate_eval accepts
//               sfq_gate_eval()  - reduces an eligibility vector to 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package sfq_clocked_gate_n_pkg;

    localparam int SFQ_MODE_W     = 2;
    localparam int SFQ_MAX_INPUTS = 32;

    typedef enum logic [SFQ_MODE_W-1:0] {
        SFQ_AND = 2'd0,
        SFQ_OR  = 2'd1,
        SFQ_XOR = 2'd2,
        SFQ_MAJ = 2'd3
    } sfq_gate_mode_e;

    // Only the low n bits of vec take part. An empty vector never produces
    // a 1: AND needs at least one set bit because n >= 2, and MAJ needs
    // more than n/2 set bits.
    function automatic logic sfq_gate_eval(
        input sfq_gate_mode_e                mode,
        input logic [SFQ_MAX_INPUTS-1:0]     vec,
        input int unsigned                   n
    );
        int unsigned cnt;
        logic        res;
        cnt = 0;
        for (int unsigned i = 0; i < SFQ_MAX_INPUTS; i++) begin
            if ((i < n) && vec[i]) begin
                cnt = cnt + 1;
            end
        end
        case (mode)
            SFQ_AND: res = (cnt == n) && (n != 0);
            SFQ_OR:  res = (cnt != 0);
            SFQ_XOR: res = (cnt % 2) == 1;
            SFQ_MAJ: res = (cnt > (n / 2));
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfq_clocked_gate_n_if.sv
`default_nettype none
// ============================================================================
// Module      : sfq_clocked_gate_n_if
// Description : Bundle between the SFQ stimulus side and a clocked N-input
//               SFQ gate.
// Signals     : sfq_clk    - SFQ clock pulse strobe            (master->slave)
//               in_pulse   - per-channel data pulse strobes     (master->slave)
//               mode       - gate function select               (master->slave)
//               out_pulse  - 1-cycle output pulse               (slave->master)
//               setup_viol - deferred-input strobe              (slave->master)
//               hold_viol  - dropped-arrival strobe             (slave->master)
//               dbl_err    - sticky per-channel double arrival  (slave->master)
//               out_count  - wrapping output pulse count        (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sfq_clocked_gate_n_if #(
    parameter int N_INPUTS = 3,
    parameter int CNT_W    = 16
);
    import sfq_clocked_gate_n_pkg::*;

    logic                   sfq_clk;
    logic [N_INPUTS-1:0]    in_pulse;
    logic [SFQ_MODE_W-1:0]  mode;
    logic                   out_pulse;
    logic                   setup_viol;
    logic                   hold_viol;
    logic [N_INPUTS-1:0]    dbl_err;
    logic [CNT_W-1:0]       out_count;

    modport master (
        output sfq_clk, in_pulse, mode,
        input  out_pulse, setup_viol, hold_viol, dbl_err, out_count
    );

    modport slave (
        input  sfq_clk, in_pulse, mode,
        output out_pulse, setup_viol, hold_viol, dbl_err, out_count
    );

endinterface
`default_nettype wire

// File: rtl/sfq_clocked_gate_n_pulse_delay.sv
`default_nettype none
// ============================================================================
// Module      : sfq_pulse_delay
// Description : Fixed-depth shift line for 1-cycle pulse strobes. Every pulse
//               on in_i reappears on out_o exactly DEPTH cycles later, so
//               back-to-back pulses travel independently. DEPTH = 0 is a
//               straight wire. Reset empties the line.
// Ports       : clk   - clock
//               rst   - asynchronous active-high clear
//               in_i  - pulse in
//               out_o - pulse out, DEPTH cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_pulse_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_o = in_i;
        end else begin : g_line
            logic [DEPTH-1:0] line_q;
            logic [DEPTH-1:0] line_d;

            always_comb begin
                line_d    = line_q << 1;
                line_d[0] = in_i;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    line_q <= '0;
                end else begin
                    line_q <= line_d;
                end
            end

            assign out_o = line_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sfq_clocked_gate_n.sv
`default_nettype none
// ============================================================================
// Module      : sfq_clocked_gate_n
// Description : N-input clocked SFQ gate with a selectable function
//               (AND/OR/XOR/MAJ). It latches data fluxons and ages them. On
//               every SFQ clock pulse it evaluates the inputs that are old
//               enough and emits an output pulse TGATE cycles later. It
//               flags setup, hold and double-arrival violations and counts
//               output pulses.
// Ports       : clk - simulation clock (1 cycle = 1 ps)
//               rst - asynchronous active-high reset
//               bus - sfq_clocked_gate_n_if.slave (sfq_clk, in_pulse, mode,
//                     out_pulse, setup_viol, hold_viol, dbl_err, out_count)
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_clocked_gate_n
    import sfq_clocked_gate_n_pkg::*;
#(
    parameter int N_INPUTS = 3,
    parameter int TSETUP   = 5,
    parameter int THOLD    = 0,
    parameter int TGATE    = 14,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sfq_clocked_gate_n_if.slave  bus
);

    localparam int AGE_W  = (TSETUP < 1) ? 1 : $clog2(TSETUP + 1);
    localparam int HOLD_W = (THOLD  < 1) ? 1 : $clog2(THOLD + 1);

    localparam logic [AGE_W-1:0]  C_AGE_MAX  = AGE_W'(TSETUP);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(THOLD);
    // A fluxon latched in the clock cycle itself is deferred only when a
    // nonzero setup time is required.
    localparam logic              C_DEFER_NEW = (TSETUP > 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_INPUTS-1:0] latch_q, latch_d;
    logic [AGE_W-1:0]    age_q [N_INPUTS];
    logic [AGE_W-1:0]    age_d [N_INPUTS];
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_INPUTS-1:0] dbl_q, dbl_d;
    logic                setup_q, setup_d;
    logic                hviol_q, hviol_d;
    logic                out_q;
    logic [CNT_W-1:0]    cnt_q;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0]         hold_now_w;
    logic                      in_hold_w;
    logic [N_INPUTS-1:0]       eligible_w;
    logic [N_INPUTS-1:0]       deferred_w;
    logic [SFQ_MAX_INPUTS-1:0] elig_ext_w;
    logic                      result_w;
    logic                      pre_out_w;

    // The hold counter saturates at THOLD, so "below THOLD" is the same as
    // "not equal to THOLD". The sfq_clk cycle itself reads as 0.
    always_comb begin
        hold_now_w = bus.sfq_clk ? '0 : hold_q;
        in_hold_w  = (hold_now_w != C_HOLD_MAX);
        hold_d     = in_hold_w ? hold_now_w + 1'b1 : hold_now_w;
    end

    // Ages saturate at TSETUP, so the setup test is an equality.
    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            eligible_w[i] = latch_q[i] && (age_q[i] == C_AGE_MAX);
        end
    end

    always_comb begin
        elig_ext_w                 = '0;
        elig_ext_w[N_INPUTS-1:0]   = eligible_w;
        result_w = bus.sfq_clk &&
                   sfq_gate_eval(sfq_gate_mode_e'(bus.mode), elig_ext_w, N_INPUTS);
    end

    // Per-channel latch/age/double-arrival update. "occupied" is a latch
    // that survives this cycle (not consumed by the current clock pulse).
    // An arrival on a channel being consumed starts a fresh latch for the
    // next window and is not a double arrival.
    always_comb begin
        latch_d    = latch_q;
        dbl_d      = dbl_q;
        deferred_w = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            logic consume;
            logic occupied;
            logic arrive;
            consume  = bus.sfq_clk && eligible_w[i];
            occupied = latch_q[i] && !consume;
            arrive   = bus.in_pulse[i] && !in_hold_w;

            latch_d[i] = occupied || arrive;
            dbl_d[i]   = dbl_q[i] || (arrive && occupied);

            if (occupied) begin
                age_d[i] = (age_q[i] != C_AGE_MAX) ? age_q[i] + 1'b1 : age_q[i];
            end else begin
                age_d[i] = '0;
            end

            deferred_w[i] = bus.sfq_clk &&
                            ((latch_q[i] && !eligible_w[i]) ||
                             (arrive && !occupied && C_DEFER_NEW));
        end
        setup_d = |deferred_w;
        hviol_d = (|bus.in_pulse) && in_hold_w;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Reset leaves the hold counter saturated, so no hold window is open
    // until the first SFQ clock pulse after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= '0;
            hold_q  <= C_HOLD_MAX;
            dbl_q   <= '0;
            setup_q <= 1'b0;
            hviol_q <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            latch_q <= latch_d;
            hold_q  <= hold_d;
            dbl_q   <= dbl_d;
            setup_q <= setup_d;
            hviol_q <= hviol_d;
            for (int i = 0; i < N_INPUTS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // The delay line supplies TGATE-1 stages; the last stage is the output
    // register, so the counter can step in the same cycle out_pulse is high.
    sfq_pulse_delay #(
        .DEPTH (TGATE - 1)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .in_i  (result_w),
        .out_o (pre_out_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= pre_out_w;
            cnt_q <= cnt_q + CNT_W'(pre_out_w);
        end
    end

    assign bus.out_pulse  = out_q;
    assign bus.setup_viol = setup_q;
    assign bus.hold_viol  = hviol_q;
    assign bus.dbl_err    = dbl_q;
    assign bus.out_count  = cnt_q;

endmodule
`default_nettype wire
